// File: rtl/gemm_tile_sequencer.sv
// gemm_tile_sequencer: ceil-tiled GEMM address/accumulator sequencer; define GEMM_SEQ_PERF_EN for perf_cycles_o/perf_tiles_o
module gemm_tile_sequencer #(
  parameter int M = 4,
  parameter int N = 4,
  parameter int K = 4,
  parameter int AddrWidth = 6,
  parameter int SizeAddrWidth = 8,
  parameter int ReadLatency = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic [SizeAddrWidth-1:0] M_size_i,
  input  logic [SizeAddrWidth-1:0] K_size_i,
  input  logic [SizeAddrWidth-1:0] N_size_i,
  output logic [AddrWidth-1:0]     sram_a_addr_o,
  output logic [AddrWidth-1:0]     sram_b_addr_o,
  output logic [AddrWidth-1:0]     sram_c_addr_o,
  output logic                     sram_c_we_o,
  output logic                     acc_en_o,
  output logic                     acc_clr_o,
  output logic [M-1:0]             row_mask_o,
  output logic [N-1:0]             col_mask_o,
  output logic [K-1:0]             k_mask_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o
`ifdef GEMM_SEQ_PERF_EN
  ,
  output logic [31:0]              perf_cycles_o,
  output logic [15:0]              perf_tiles_o
`endif
);
  localparam int SW = SizeAddrWidth;
  localparam int PW = 2 + M + N + K;
  localparam logic [SW-1:0] sz_one = 1;
  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, WRITE, FIN} state_t;
  state_t st, st_n;
  logic [SW-1:0] m_sz, k_sz, n_sz, mt_c, kt_c, nt_c;
  logic [SW-1:0] mt, kt, nt, mt_n, kt_n, nt_n;
  logic [31:0] mt_in, kt_in, nt_in;
  logic [1:0] dc;
  logic err_q, err_pend, bad, accept, last_k, last_n, last_tile;
  logic [M-1:0] row_m;
  logic [N-1:0] col_m;
  logic [K-1:0] k_m;
  logic [PW-1:0] push;
  logic [PW-1:0] pipe [ReadLatency];
  always_comb begin
    mt_in = (32'(M_size_i) + 32'(M) - 32'd1) / 32'(M);
    kt_in = (32'(K_size_i) + 32'(K) - 32'd1) / 32'(K);
    nt_in = (32'(N_size_i) + 32'(N) - 32'd1) / 32'(N);
    bad = M_size_i == '0 || K_size_i == '0 || N_size_i == '0 ||
          mt_in * kt_in > 32'(2 ** AddrWidth) || kt_in * nt_in > 32'(2 ** AddrWidth) ||
          mt_in * nt_in > 32'(2 ** AddrWidth);
    accept = st == IDLE && start_i;
    last_k = kt == kt_c - sz_one;
    last_n = nt == nt_c - sz_one;
    last_tile = last_n && mt == mt_c - sz_one;
  end
  always_comb begin
    for (int i = 0; i < M; i++) row_m[i] = 32'(mt) * 32'(M) + 32'(i) < 32'(m_sz);
    for (int i = 0; i < N; i++) col_m[i] = 32'(nt) * 32'(N) + 32'(i) < 32'(n_sz);
    for (int i = 0; i < K; i++) k_m[i] = 32'(kt) * 32'(K) + 32'(i) < 32'(k_sz);
    push = st == ISSUE ? {1'b1, kt == '0, row_m, col_m, k_m} : '0;
  end
  always_comb begin
    st_n = st;
    mt_n = mt;
    kt_n = kt;
    nt_n = nt;
    case (st)
      IDLE: if (start_i) begin
        st_n = bad ? FIN : ISSUE;
        mt_n = '0;
        kt_n = '0;
        nt_n = '0;
      end
      ISSUE: if (last_k) st_n = DRAIN; else kt_n = kt + sz_one;
      DRAIN: st_n = dc == 2'(ReadLatency - 1) ? WRITE : DRAIN;
      WRITE: begin
        st_n = last_tile ? FIN : ISSUE;
        if (!last_tile) begin
          kt_n = '0;
          nt_n = last_n ? '0 : nt + sz_one;
          mt_n = last_n ? mt + sz_one : mt;
        end
      end
      // a rejected job spends one extra FIN cycle before the done/err pulse
      FIN: st_n = err_pend ? FIN : IDLE;
      default: st_n = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      st <= IDLE;
      {mt, kt, nt, m_sz, k_sz, n_sz, mt_c, kt_c, nt_c} <= '0;
      {dc, err_q, err_pend} <= '0;
      {sram_a_addr_o, sram_b_addr_o, sram_c_addr_o} <= '0;
      for (int i = 0; i < ReadLatency; i++) pipe[i] <= '0;
    end else begin
      st <= st_n;
      mt <= mt_n;
      kt <= kt_n;
      nt <= nt_n;
      dc <= st == DRAIN ? dc + 2'd1 : 2'd0;
      if (accept) begin
        {m_sz, k_sz, n_sz} <= {M_size_i, K_size_i, N_size_i};
        mt_c <= SW'(mt_in);
        kt_c <= SW'(kt_in);
        nt_c <= SW'(nt_in);
        err_q <= bad;
        err_pend <= bad;
      end else if (st == FIN) err_pend <= 1'b0;
      if (st_n == ISSUE) begin
        sram_a_addr_o <= AddrWidth'(32'(mt_n) * 32'(kt_c) + 32'(kt_n));
        sram_b_addr_o <= AddrWidth'(32'(kt_n) * 32'(nt_c) + 32'(nt_n));
      end
      if (st_n == WRITE) sram_c_addr_o <= AddrWidth'(32'(mt) * 32'(nt_c) + 32'(nt));
      pipe[0] <= push;
      for (int i = 1; i < ReadLatency; i++) pipe[i] <= pipe[i-1];
    end
  assign {acc_en_o, acc_clr_o, row_mask_o, col_mask_o, k_mask_o} = pipe[ReadLatency-1];
  assign sram_c_we_o = st == WRITE;
  assign done_o = st == FIN && !err_pend;
  assign err_o = done_o && err_q;
  assign busy_o = st != IDLE && !done_o;
`ifdef GEMM_SEQ_PERF_EN
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      perf_cycles_o <= '0;
      perf_tiles_o <= '0;
    end else if (accept) begin
      perf_cycles_o <= '0;
      perf_tiles_o <= '0;
    end else begin
      if (busy_o && !(&perf_cycles_o)) perf_cycles_o <= perf_cycles_o + 32'd1;
      if (sram_c_we_o && !(&perf_tiles_o)) perf_tiles_o <= perf_tiles_o + 16'd1;
    end
`endif
endmodule

// File: tb/tb_gemm_tile_sequencer.sv
// tb_gemm_tile_sequencer: random and directed jobs checked cycle by cycle against a tile-loop reference trace
module tb_gemm_tile_sequencer;
  localparam int RL = 1;
  localparam int AW = 6;
  localparam int DEPTH = 2 ** AW;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [7:0] m_size = '0, k_size = '0, n_size = '0;
  logic [AW-1:0] a_addr, b_addr, c_addr;
  logic c_we, acc_en, acc_clr, busy, done, err;
  logic [3:0] row_mask, col_mask, k_mask;
`ifdef GEMM_SEQ_PERF_EN
  logic [31:0] perf_cycles;
  logic [15:0] perf_tiles;
`endif
  int n_checks = 0, n_fails = 0;
  typedef struct packed {
    logic [AW-1:0] a, b, c;
    logic we, en, clr;
    logic [3:0] rm, cm, km;
    logic busy, done, err;
  } obs_t;
  obs_t exp_q[$];
  logic [AW-1:0] ha = '0, hb = '0, hc = '0;

  always #5 clk = ~clk;

  gemm_tile_sequencer #(.ReadLatency(RL)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .M_size_i(m_size), .K_size_i(k_size), .N_size_i(n_size),
    .sram_a_addr_o(a_addr), .sram_b_addr_o(b_addr), .sram_c_addr_o(c_addr),
    .sram_c_we_o(c_we), .acc_en_o(acc_en), .acc_clr_o(acc_clr),
    .row_mask_o(row_mask), .col_mask_o(col_mask), .k_mask_o(k_mask),
    .busy_o(busy), .done_o(done), .err_o(err)
`ifdef GEMM_SEQ_PERF_EN
    , .perf_cycles_o(perf_cycles), .perf_tiles_o(perf_tiles)
`endif
  );

  function automatic obs_t sample();
    return {a_addr, b_addr, c_addr, c_we, acc_en, acc_clr, row_mask, col_mask, k_mask, busy, done, err};
  endfunction

  function automatic int cdiv(int x);
    return (x + 3) / 4;
  endfunction

  function automatic bit rejected(int m, int k, int n);
    return m == 0 || k == 0 || n == 0 || cdiv(m) * cdiv(k) > DEPTH ||
           cdiv(k) * cdiv(n) > DEPTH || cdiv(m) * cdiv(n) > DEPTH;
  endfunction

  task automatic check(string tag, logic [63:0] got, logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // Expected per-cycle outputs, offset 1 = first cycle after the start edge
  task automatic build(int m, int k, int n);
    int mtc, ktc, ntc;
    int iss[$];
    obs_t beats[$];
    obs_t e, bt, t;
    mtc = cdiv(m);
    ktc = cdiv(k);
    ntc = cdiv(n);
    exp_q.delete();
    e = '0;
    e.a = ha;
    e.b = hb;
    e.c = hc;
    if (rejected(m, k, n)) begin
      e.busy = 1'b1;
      exp_q.push_back(e);
      e.busy = 1'b0;
      e.done = 1'b1;
      e.err = 1'b1;
      exp_q.push_back(e);
      return;
    end
    for (int mt = 0; mt < mtc; mt++)
      for (int nt = 0; nt < ntc; nt++) begin
        for (int kt = 0; kt < ktc; kt++) begin
          e.a = AW'(mt * ktc + kt);
          e.b = AW'(kt * ntc + nt);
          e.busy = 1'b1;
          iss.push_back(exp_q.size());
          exp_q.push_back(e);
          bt = '0;
          bt.en = 1'b1;
          bt.clr = kt == 0;
          for (int i = 0; i < 4; i++) begin
            bt.rm[i] = mt * 4 + i < m;
            bt.cm[i] = nt * 4 + i < n;
            bt.km[i] = kt * 4 + i < k;
          end
          beats.push_back(bt);
        end
        for (int d = 0; d < RL; d++) exp_q.push_back(e);
        e.c = AW'(mt * ntc + nt);
        e.we = 1'b1;
        exp_q.push_back(e);
        e.we = 1'b0;
      end
    e.busy = 1'b0;
    e.done = 1'b1;
    exp_q.push_back(e);
    foreach (iss[i]) begin
      t = exp_q[iss[i] + RL];
      t.en = beats[i].en;
      t.clr = beats[i].clr;
      t.rm = beats[i].rm;
      t.cm = beats[i].cm;
      t.km = beats[i].km;
      exp_q[iss[i] + RL] = t;
    end
    ha = e.a;
    hb = e.b;
    hc = e.c;
  endtask

  task automatic run_job(int m, int k, int n, int abort = -1);
    int len, lat, want;
    obs_t idle;
    @(negedge clk);
    m_size = 8'(m);
    k_size = 8'(k);
    n_size = 8'(n);
    start = 1'b1;
    build(m, k, n);
    len = exp_q.size();
    lat = -1;
    want = rejected(m, k, n) ? 2 : cdiv(m) * cdiv(n) * (cdiv(k) + RL + 1) + 1;
    for (int j = 0; j < len; j++) begin
      @(negedge clk);
      if (j == abort) begin
        rst = 1'b1;
        start = 1'b0;
        #1;
        check("rst_async", 64'(sample()), '0);
        ha = '0;
        hb = '0;
        hc = '0;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check("post_rst", 64'(sample()), '0);
        end
        return;
      end
      check($sformatf("cyc%0d_%0dx%0dx%0d", j + 1, m, k, n), 64'(sample()), 64'(exp_q[j]));
      if (done && lat < 0) lat = j + 1;
      start = j < len - 1 && $urandom_range(0, 3) == 0;
      m_size = 8'($urandom);
      k_size = 8'($urandom);
      n_size = 8'($urandom);
    end
    start = 1'b0;
    check("latency", 64'(lat), 64'(want));
    @(negedge clk);
    idle = '0;
    idle.a = ha;
    idle.b = hb;
    idle.c = hc;
    check("idle", 64'(sample()), 64'(idle));
`ifdef GEMM_SEQ_PERF_EN
    check("perf_tiles", 64'(perf_tiles), rejected(m, k, n) ? 64'd0 : 64'(cdiv(m) * cdiv(n)));
    check("perf_cycles", 64'(perf_cycles), 64'(len - 1));
`endif
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("reset", 64'(sample()), '0);
    rst = 1'b0;
    run_job(32, 32, 32);
    run_job(5, 7, 6);
    run_job(4, 0, 4);
    run_job(16, 16, 16, 3 * (4 + RL + 1) + 1);
    run_job(16, 16, 16);
    run_job(8, 8, 8);
    run_job(33, 8, 32);
    run_job(1, 1, 1);
    repeat (25) run_job($urandom_range(0, 36), $urandom_range(0, 36), $urandom_range(0, 36));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
